// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//   Walks the microprogram of an accepted opcode through an external
//   synchronous microcode ROM. Each microinstruction is handed to the
//   downstream executor as an r_addr/w_addr pair for one EXEC cycle, or
//   for longer if the executor stalls it.
//
// Ports
//   clk, reset_n     : clock, asynchronous active-low reset
//   start, opcode    : run request and its opcode (taken only while ready=1)
//   ready, busy      : idle / running indication
//   flag             : branch condition from the datapath, sampled in EXEC
//   hold             : executor stall, freezes EXEC
//   uc_addr, uc_data : ROM address (the registered uPC) and ROM read data
//   r_addr, w_addr   : bus source/destination selects, 0 unless step_valid
//   step_valid       : r_addr/w_addr are live this cycle
//   done             : one-cycle pulse on return to idle
//   error            : sticky watchdog abort, cleared by the next start
module microcode_sequencer #(
  parameter int UPC_W     = 8,
  parameter int UW        = 19 + UPC_W,
  parameter int MAX_STEPS = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       opcode,
  output logic             ready,
  output logic             busy,
  input  logic             flag,
  input  logic             hold,
  output logic [UPC_W-1:0] uc_addr,
  input  logic [UW-1:0]    uc_data,
  output logic [7:0]       r_addr,
  output logic [7:0]       w_addr,
  output logic             step_valid,
  output logic             done,
  output logic             error
);

  localparam int CNT_W = $clog2(MAX_STEPS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_EXEC  = 2'd3
  } state_t;

  state_t           state;
  logic [UPC_W-1:0] upc;
  logic [CNT_W-1:0] step_cnt;
  logic [CNT_W-1:0] step_cnt_inc;
  logic [UPC_W-1:0] entry_addr;

  // Control half of the fetched microword; the select fields go straight
  // to the r_addr/w_addr registers instead.
  logic [UW-1:16]   ir_ctrl;
  logic             ir_end;
  logic             ir_branch;
  logic             ir_cond_en;
  logic [UPC_W-1:0] ir_target;

  // Entry address is the opcode zero-extended or truncated to UPC_W.
  generate
    if (UPC_W == 8) begin : g_entry_eq
      assign entry_addr = opcode;
    end else if (UPC_W > 8) begin : g_entry_ext
      assign entry_addr = {{(UPC_W-8){1'b0}}, opcode};
    end else begin : g_entry_trunc
      assign entry_addr = opcode[UPC_W-1:0];
    end
  endgenerate

  assign ir_end     = ir_ctrl[16];
  assign ir_branch  = ir_ctrl[17];
  assign ir_cond_en = ir_ctrl[18];
  assign ir_target  = ir_ctrl[18+UPC_W:19];

  assign step_cnt_inc = step_cnt + CNT_W'(1);

  assign ready   = (state == S_IDLE);
  assign busy    = ~ready;
  assign uc_addr = upc;

  // Instruction register: pure data, loaded when the ROM word is valid.
  always_ff @(posedge clk) begin
    if (state == S_WAIT) begin
      ir_ctrl <= uc_data[UW-1:16];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      upc        <= '0;
      step_cnt   <= '0;
      r_addr     <= 8'h00;
      w_addr     <= 8'h00;
      step_valid <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // IDLE: accept a new opcode; also taken in the done cycle so
        // consecutive opcodes run without a bubble.
        S_IDLE: begin
          if (start) begin
            upc      <= entry_addr;
            error    <= 1'b0;
            step_cnt <= '0;
            state    <= S_FETCH;
          end
        end
        // FETCH: uPC is on uc_addr and the ROM samples it at this edge.
        S_FETCH: begin
          state <= S_WAIT;
        end
        // WAIT: ROM word is valid; register the selects for EXEC.
        S_WAIT: begin
          r_addr     <= uc_data[15:8];
          w_addr     <= uc_data[7:0];
          step_valid <= 1'b1;
          state      <= S_EXEC;
        end
        // EXEC: selects are live; on release pick the next uPC. End wins
        // over the watchdog, the watchdog over any branch.
        S_EXEC: begin
          if (!hold) begin
            step_cnt   <= step_cnt_inc;
            step_valid <= 1'b0;
            r_addr     <= 8'h00;
            w_addr     <= 8'h00;
            if (ir_end) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else if (step_cnt_inc == CNT_W'(MAX_STEPS)) begin
              done  <= 1'b1;
              error <= 1'b1;
              state <= S_IDLE;
            end else if (ir_branch && (!ir_cond_en || flag)) begin
              upc   <= ir_target;
              state <= S_FETCH;
            end else begin
              upc   <= upc + UPC_W'(1);
              state <= S_FETCH;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed testbench for microcode_sequencer with a behavioural
// synchronous ROM (data valid one cycle after the address).
module tb_microcode_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  opcode;
  logic        ready, busy, flag, hold;
  logic [7:0]  uc_addr;
  logic [26:0] uc_data;
  logic [7:0]  r_addr, w_addr;
  logic        step_valid, done, error;

  logic [26:0] rom [0:255];

  int errors = 0;
  int checks = 0;

  microcode_sequencer #(.UPC_W(8), .UW(27), .MAX_STEPS(64)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
    .ready(ready), .busy(busy), .flag(flag), .hold(hold),
    .uc_addr(uc_addr), .uc_data(uc_data), .r_addr(r_addr), .w_addr(w_addr),
    .step_valid(step_valid), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) uc_data <= rom[uc_addr];

  function automatic logic [26:0] mkw(input logic [7:0] r, input logic [7:0] w,
                                      input logic e, input logic b, input logic c,
                                      input logic [7:0] t);
    return {t, c, b, e, r, w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge; returns in cycle 1 (FETCH).
  task automatic kick(input logic [7:0] op);
    start  = 1'b1;
    opcode = op;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s: done=%b after %0d cycles, want 1", name, done, n);
    end
    tick();
  endtask

  task automatic test_reset();
    checks++;
    if ({ready, busy, step_valid, done, error} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: rdy/busy/sv/done/err=%b want 10000",
               {ready, busy, step_valid, done, error});
    end
    checks++;
    if ({uc_addr, r_addr, w_addr} !== 24'h0) begin
      errors++;
      $display("FAIL reset_addr: uc/r/w=%h want 000000", {uc_addr, r_addr, w_addr});
    end
  endtask

  task automatic test_linear();
    kick(8'h10);
    checks++;
    if (uc_addr !== 8'h10 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lin_c1: uc_addr=%h busy=%b want 10 1", uc_addr, busy);
    end
    tick(); tick();
    checks++;
    if ({step_valid, r_addr, w_addr} !== {1'b1, 8'h03, 8'h05}) begin
      errors++;
      $display("FAIL lin_c3: sv/r/w=%b %h %h want 1 03 05", step_valid, r_addr, w_addr);
    end
    tick();
    checks++;
    if ({step_valid, r_addr, w_addr, uc_addr} !== {1'b0, 8'h00, 8'h00, 8'h11}) begin
      errors++;
      $display("FAIL lin_c4: sv/r/w/uc=%b %h %h %h want 0 00 00 11",
               step_valid, r_addr, w_addr, uc_addr);
    end
    tick(); tick();
    checks++;
    if ({step_valid, r_addr, w_addr} !== {1'b1, 8'h05, 8'h07}) begin
      errors++;
      $display("FAIL lin_c6: sv/r/w=%b %h %h want 1 05 07", step_valid, r_addr, w_addr);
    end
    tick();
    checks++;
    if ({done, ready, step_valid, error} !== 4'b1100) begin
      errors++;
      $display("FAIL lin_c7: done/rdy/sv/err=%b want 1100", {done, ready, step_valid, error});
    end
    tick();
    checks++;
    if ({done, ready} !== 2'b01) begin
      errors++;
      $display("FAIL lin_c8: done/rdy=%b want 01", {done, ready});
    end
  endtask

  task automatic run_branch(input string name, input logic [7:0] op,
                            input logic f, input logic [7:0] exp_next);
    flag = f;
    kick(op);
    tick(); tick(); tick();
    checks++;
    if (uc_addr !== exp_next || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s: uc_addr=%h busy=%b want %h 1", name, uc_addr, busy, exp_next);
    end
    wait_done(name, 20);
    flag = 1'b0;
  endtask

  task automatic test_branch();
    run_branch("br_cond_f0", 8'h20, 1'b0, 8'h21);
    run_branch("br_cond_f1", 8'h20, 1'b1, 8'h40);
    run_branch("br_uncond",  8'h50, 1'b0, 8'h60);
    // end=1 together with branch=1 must finish instead of branching
    kick(8'h70);
    tick(); tick(); tick();
    checks++;
    if ({done, ready} !== 2'b11) begin
      errors++;
      $display("FAIL end_over_branch: done/rdy=%b want 11", {done, ready});
    end
    tick();
  endtask

  task automatic test_hold();
    kick(8'h10);
    tick(); tick();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({step_valid, r_addr, w_addr, uc_addr} !== {1'b1, 8'h03, 8'h05, 8'h10}) begin
        errors++;
        $display("FAIL hold_%0d: sv/r/w/uc=%b %h %h %h want 1 03 05 10",
                 i, step_valid, r_addr, w_addr, uc_addr);
      end
      if (i == 3) hold = 1'b0;
    end
    tick();
    checks++;
    if ({step_valid, uc_addr} !== {1'b0, 8'h11}) begin
      errors++;
      $display("FAIL hold_release: sv/uc=%b %h want 0 11", step_valid, uc_addr);
    end
    wait_done("hold_done", 20);
  endtask

  task automatic test_wrap();
    kick(8'hFF);
    tick(); tick();
    checks++;
    if ({step_valid, r_addr, w_addr} !== {1'b1, 8'h01, 8'h02}) begin
      errors++;
      $display("FAIL wrap_exec: sv/r/w=%b %h %h want 1 01 02", step_valid, r_addr, w_addr);
    end
    tick();
    checks++;
    if (uc_addr !== 8'h00) begin
      errors++;
      $display("FAIL wrap_addr: uc_addr=%h want 00", uc_addr);
    end
    wait_done("wrap_done", 20);
  endtask

  task automatic run_watchdog(input string name);
    int n_exec;
    int n;
    n_exec = 0;
    n = 0;
    kick(8'h30);
    while (!done && n < 400) begin
      if (step_valid) n_exec++;
      tick();
      n++;
    end
    checks++;
    if (n_exec != 64) begin
      errors++;
      $display("FAIL %s_steps: exec cycles=%0d want 64", name, n_exec);
    end
    checks++;
    if ({done, error, ready} !== 3'b111) begin
      errors++;
      $display("FAIL %s_abort: done/err/rdy=%b want 111", name, {done, error, ready});
    end
  endtask

  task automatic test_watchdog();
    run_watchdog("wdog");
    tick(); tick(); tick();
    checks++;
    if ({done, error} !== 2'b01) begin
      errors++;
      $display("FAIL wdog_sticky: done/err=%b want 01", {done, error});
    end
    // async reset in idle clears the sticky flag
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL wdog_reset_clr: error=%b want 0", error);
    end
    tick();
    reset_n = 1'b1;
    tick();
    run_watchdog("wdog2");
    tick();
    kick(8'h10);
    checks++;
    if (error !== 1'b0 || uc_addr !== 8'h10) begin
      errors++;
      $display("FAIL wdog_start_clr: err/uc=%b %h want 0 10", error, uc_addr);
    end
    wait_done("wdog_next", 20);
  endtask

  task automatic test_async_reset();
    kick(8'h10);
    tick(); tick();
    hold = 1'b1;
    checks++;
    if (step_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: step_valid=%b want 1", step_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ready, busy, step_valid, error, r_addr, w_addr, uc_addr} !== {4'b1000, 24'h0}) begin
      errors++;
      $display("FAIL areset: rdy/busy/sv/err=%b r/w/uc=%h %h %h want 1000 00 00 00",
               {ready, busy, step_valid, error}, r_addr, w_addr, uc_addr);
    end
    hold = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    kick(8'h10);
    start  = 1'b1;
    opcode = 8'h40;
    tick();
    start  = 1'b0;
    tick();
    checks++;
    if ({step_valid, r_addr, w_addr} !== {1'b1, 8'h03, 8'h05}) begin
      errors++;
      $display("FAIL busy_start: sv/r/w=%b %h %h want 1 03 05", step_valid, r_addr, w_addr);
    end
    tick();
    checks++;
    if (uc_addr !== 8'h11) begin
      errors++;
      $display("FAIL busy_start_addr: uc_addr=%h want 11", uc_addr);
    end
    tick(); tick(); tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: done=%b want 1", done);
    end
    kick(8'h70);
    checks++;
    if ({uc_addr, busy, done} !== {8'h70, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_next: uc/busy/done=%h %b %b want 70 1 0", uc_addr, busy, done);
    end
    wait_done("b2b_end", 20);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[8'h10] = mkw(8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00);
    rom[8'h11] = mkw(8'h05, 8'h07, 1'b1, 1'b0, 1'b0, 8'h00);
    rom[8'h20] = mkw(8'h11, 8'h22, 1'b0, 1'b1, 1'b1, 8'h40);
    rom[8'h21] = mkw(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    rom[8'h40] = mkw(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    rom[8'h50] = mkw(8'h12, 8'h34, 1'b0, 1'b1, 1'b0, 8'h60);
    rom[8'h60] = mkw(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    rom[8'h70] = mkw(8'h09, 8'h08, 1'b1, 1'b1, 1'b0, 8'h40);
    rom[8'hFF] = mkw(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00);
    rom[8'h00] = mkw(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    rom[8'h30] = mkw(8'h0A, 8'h0B, 1'b0, 1'b1, 1'b0, 8'h30);

    reset_n = 1'b0;
    start   = 1'b0;
    opcode  = 8'h00;
    flag    = 1'b0;
    hold    = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    test_reset();
    test_linear();
    test_branch();
    test_hold();
    test_wrap();
    test_watchdog();
    test_async_reset();
    test_back_to_back();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
